// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated per-channel rising-edge counter with latched results
module freq_meter #(
  parameter int CH_NUM    = 4,
  parameter int CNT_NBIT  = 32,
  parameter int GATE_NBIT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [GATE_NBIT-1:0]       i_gate_len,
  input  logic [CH_NUM-1:0]          i_ch_en,
  input  logic [CH_NUM-1:0]          freq_io,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [CH_NUM*CNT_NBIT-1:0] o_cnt,
  output logic [CH_NUM-1:0]          o_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_LATCH} state_t;

  state_t state, state_nxt;

  logic [CH_NUM-1:0]                s1, s2, s3;
  logic [CH_NUM-1:0]                rise;
  logic [GATE_NBIT-1:0]             gate_len_q;
  logic [GATE_NBIT-1:0]             timer;
  logic [CH_NUM-1:0]                en_q;
  logic [CH_NUM-1:0][CNT_NBIT-1:0]  cnt;
  logic [CH_NUM-1:0]                ovf;

  assign rise   = s2 & ~s3;
  assign o_busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_ARM;
      // A zero-length gate goes straight to LATCH so the result is all zeros.
      S_ARM:   state_nxt = (gate_len_q == '0) ? S_LATCH : S_GATE;
      S_GATE:  if (timer == GATE_NBIT'(1)) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      gate_len_q <= '0;
      timer      <= '0;
      en_q       <= '0;
      cnt        <= '0;
      ovf        <= '0;
      o_done     <= 1'b0;
      o_cnt      <= '0;
      o_ovf      <= '0;
    end else begin
      state  <= state_nxt;
      s1     <= freq_io;
      s2     <= s1;
      s3     <= s2;
      o_done <= (state == S_LATCH);
      case (state)
        S_IDLE: begin
          if (i_start) begin
            gate_len_q <= i_gate_len;
            en_q       <= i_ch_en;
          end
        end
        S_ARM: begin
          timer <= gate_len_q;
          cnt   <= '0;
          ovf   <= '0;
        end
        S_GATE: begin
          timer <= timer - GATE_NBIT'(1);
          // Counters saturate at all-ones; an edge arriving there flags overflow.
          for (int n = 0; n < CH_NUM; n++) begin
            if (en_q[n] && rise[n]) begin
              if (cnt[n] == '1) ovf[n] <= 1'b1;
              else              cnt[n] <= cnt[n] + CNT_NBIT'(1);
            end
          end
        end
        S_LATCH: begin
          o_cnt <= cnt;
          o_ovf <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized self-checking bench for freq_meter
module tb_freq_meter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [31:0]  i_gate_len;
  logic [3:0]   i_ch_en;
  logic [3:0]   freq_io = 4'h0;
  logic         o_busy, o_done;
  logic [127:0] o_cnt;
  logic [3:0]   o_ovf;
  logic         sat_busy, sat_done;
  logic [15:0]  sat_cnt;
  logic [3:0]   sat_ovf;

  int checks = 0;
  int errors = 0;

  int half [4] = '{0, 0, 0, 0};
  int ph   [4] = '{0, 0, 0, 0};

  logic [3:0] hist [0:65535];
  int edge_no = 0;

  freq_meter dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_gate_len(i_gate_len),
    .i_ch_en(i_ch_en), .freq_io(freq_io), .o_busy(o_busy), .o_done(o_done),
    .o_cnt(o_cnt), .o_ovf(o_ovf)
  );

  freq_meter #(.CNT_NBIT(4)) dut_sat (
    .clk(clk), .rst(rst), .i_start(i_start), .i_gate_len(i_gate_len),
    .i_ch_en(i_ch_en), .freq_io(freq_io), .o_busy(sat_busy), .o_done(sat_done),
    .o_cnt(sat_cnt), .o_ovf(sat_ovf)
  );

  always #5 clk = ~clk;

  // Channel stimulus: half==0 gives random bits, otherwise a square wave of period 2*half.
  always @(negedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (half[n] == 0) begin
        freq_io[n] = 1'($urandom_range(0, 1));
      end else begin
        ph[n]++;
        if (ph[n] >= half[n]) begin
          ph[n] = 0;
          freq_io[n] = ~freq_io[n];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (edge_no < 65536) hist[edge_no] = freq_io;
    edge_no++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rising transitions of channel n in the input as sampled at edges k-1 .. k+len-1.
  function automatic int rises(int n, int k, int len);
    int c = 0;
    for (int j = k; j < k + len; j++)
      if (hist[j][n] && !hist[j-1][n]) c++;
    return c;
  endfunction

  task automatic run_meas(input int len, input logic [3:0] en, input bit busy_start, input string tag);
    int k, lat, c, c_sat;
    @(negedge clk);
    i_start    = 1'b1;
    i_gate_len = 32'(len);
    i_ch_en    = en;
    @(posedge clk); #1;
    k = edge_no - 1;
    chk({tag, "_busy_arm"}, 64'(o_busy), 64'd1);
    i_start    = 1'b0;
    i_gate_len = $urandom;
    i_ch_en    = 4'($urandom);
    lat = 0;
    while (!o_done && lat < len + 50) begin
      @(posedge clk); #1;
      lat++;
      if (busy_start) i_start = (lat == len / 2);
    end
    i_start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(len + 2));
    chk({tag, "_done"}, 64'(o_done), 64'd1);
    for (int n = 0; n < 4; n++) begin
      c     = en[n] ? rises(n, k, len) : 0;
      c_sat = (c > 15) ? 15 : c;
      chk($sformatf("%s_cnt%0d", tag, n), 64'(o_cnt[n*32 +: 32]), 64'(c));
      chk($sformatf("%s_ovf%0d", tag, n), 64'(o_ovf[n]), 64'd0);
      chk($sformatf("%s_satcnt%0d", tag, n), 64'(sat_cnt[n*4 +: 4]), 64'(c_sat));
      chk($sformatf("%s_satovf%0d", tag, n), 64'(sat_ovf[n]), 64'(c > 15));
    end
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(o_done), 64'd0);
    chk({tag, "_busy_idle"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    int dones;
    rst        = 1'b1;
    i_start    = 1'b0;
    i_gate_len = '0;
    i_ch_en    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_cnt", o_cnt[63:0] | o_cnt[127:64], 64'd0);
    chk("rst_ovf", 64'({o_ovf, sat_ovf}), 64'd0);
    chk("rst_satcnt", 64'(sat_cnt), 64'd0);
    dones = 0;
    repeat (20) begin @(posedge clk); #1; if (o_done) dones++; end
    chk("rst_idle_done", 64'(dones), 64'd0);

    half = '{5, 0, 0, 0};
    run_meas(1000, 4'b0001, 1'b0, "basic");
    chk("basic_ch0_range", 64'(o_cnt[31:0] == 100 || o_cnt[31:0] == 101), 64'd1);
    chk("basic_ch123", 64'(o_cnt[127:32] == '0), 64'd1);

    half = '{2, 4, 8, 16};
    run_meas(256, 4'b1011, 1'b0, "multi");
    chk("multi_ch0", 64'(o_cnt[31:0]), 64'd64);
    chk("multi_ch1", 64'(o_cnt[63:32]), 64'd32);
    chk("multi_ch2", 64'(o_cnt[95:64]), 64'd0);
    chk("multi_ch3", 64'(o_cnt[127:96]), 64'd8);

    half = '{0, 0, 0, 0};
    run_meas(0, 4'hF, 1'b0, "zero");
    chk("zero_all", 64'(o_cnt == '0), 64'd1);

    run_meas(100, 4'hF, 1'b1, "busy_start");
    dones = 0;
    repeat (120) begin @(posedge clk); #1; if (o_done || o_busy) dones++; end
    chk("busy_start_not_queued", 64'(dones), 64'd0);

    half = '{1, 0, 0, 0};
    run_meas(64, 4'b0001, 1'b0, "sat");
    chk("sat_cnt15", 64'(sat_cnt[3:0]), 64'd15);
    chk("sat_ovf1", 64'(sat_ovf[0]), 64'd1);
    chk("sat_wide32", 64'(o_cnt[31:0]), 64'd32);
    run_meas(8, 4'b0001, 1'b0, "unsat");
    chk("unsat_cnt4", 64'(sat_cnt[3:0]), 64'd4);
    chk("unsat_ovf0", 64'(sat_ovf[0]), 64'd0);

    half = '{0, 0, 0, 0};
    for (int r = 0; r < 6; r++)
      run_meas($urandom_range(1, 300), 4'($urandom), 1'b0, $sformatf("rand%0d", r));

    @(negedge clk);
    i_start = 1'b1; i_gate_len = 32'd500; i_ch_en = 4'hF;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    chk("midrst_cnt", 64'(o_cnt == '0 && sat_cnt == '0), 64'd1);
    chk("midrst_ovf", 64'({o_ovf, sat_ovf}), 64'd0);
    dones = 0;
    repeat (600) begin @(posedge clk); #1; if (o_done || o_busy) dones++; end
    chk("midrst_no_done", 64'(dones), 64'd0);
    run_meas(50, 4'hF, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
